// File: rtl/mem_once_pkg.sv
// Shared types and sizes for the write-once memory controller.
// Imported by the interface, checker and top.
package mem_once_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ACCEPT,
    COMMIT,
    FULL
  } state_e;

endpackage

// File: rtl/mem_once_writer_if.sv
// Valid/ready write-request channel.
// Master drives the request, slave answers with ready.
interface mem_once_writer_if #(
  parameter int AW = mem_once_pkg::AW,
  parameter int DW = mem_once_pkg::DW
);

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/mem_once_check.sv
// Combinational legality check of a write request.
// Flags reused address, zero data and bit overlap.
module mem_once_check #(
  parameter int AW = mem_once_pkg::AW,
  parameter int DW = mem_once_pkg::DW
) (
  input  logic [AW-1:0]    addr_i,
  input  logic [DW-1:0]    data_i,
  input  logic [2**AW-1:0] used_addr_i,
  input  logic [DW-1:0]    used_dbits_i,
  output logic             dup_o,
  output logic             zero_o,
  output logic             ovl_o,
  output logic             legal_o
);

  assign dup_o   = used_addr_i[addr_i];
  assign zero_o  = (data_i == '0);
  assign ovl_o   = ((data_i & used_dbits_i) != '0);
  assign legal_o = !(dup_o || zero_o || ovl_o);

endmodule

// File: rtl/mem_once_writer.sv
// Write-once controller: commits legal requests to memory,
// tracks used addresses/bits and flags illegal requests.
module mem_once_writer #(
  parameter int AW = mem_once_pkg::AW,
  parameter int DW = mem_once_pkg::DW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  mem_once_writer_if.slave wr,
  output logic             mem_we,
  output logic [AW-1:0]    mem_waddr,
  output logic [DW-1:0]    mem_wdata,
  output logic [2**AW-1:0] used_addr,
  output logic [DW-1:0]    used_dbits,
  output logic [AW:0]      count,
  output logic             done,
  output logic             err_dup,
  output logic             err_zero,
  output logic             err_overlap
);

  import mem_once_pkg::*;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(2**AW);

  state_e           state_q;
  logic             mem_we_q;
  logic [AW-1:0]    waddr_q;
  logic [DW-1:0]    wdata_q;
  logic [2**AW-1:0] used_q;
  logic [DW-1:0]    dbits_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             done_q;
  logic             edup_q;
  logic             ezero_q;
  logic             eovl_q;

  logic dup;
  logic zero;
  logic ovl;
  logic legal;
  logic hs;

  mem_once_check #(
    .AW (AW),
    .DW (DW)
  ) u_check (
    .addr_i       (wr.wr_addr),
    .data_i       (wr.wr_data),
    .used_addr_i  (used_q),
    .used_dbits_i (dbits_q),
    .dup_o        (dup),
    .zero_o       (zero),
    .ovl_o        (ovl),
    .legal_o      (legal)
  );

  // Ready only in ACCEPT, never while clearing or held in reset.
  assign wr.wr_ready = resetn && (state_q == ACCEPT) && !clear;
  assign hs          = wr.wr_valid && wr.wr_ready;
  assign count_d     = count_q + (AW+1)'(1);

  // FSM, bookkeeping and registered write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ACCEPT;
      mem_we_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      used_q   <= '0;
      dbits_q  <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      edup_q   <= 1'b0;
      ezero_q  <= 1'b0;
      eovl_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= ACCEPT;
      mem_we_q <= 1'b0;
      used_q   <= '0;
      dbits_q  <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      edup_q   <= 1'b0;
      ezero_q  <= 1'b0;
      eovl_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACCEPT: begin
          mem_we_q <= 1'b0;
          if (hs && legal) begin
            waddr_q  <= wr.wr_addr;
            wdata_q  <= wr.wr_data;
            mem_we_q <= 1'b1;
            state_q  <= COMMIT;
          end else if (hs) begin
            if (dup)  edup_q  <= 1'b1;
            if (zero) ezero_q <= 1'b1;
            if (ovl)  eovl_q  <= 1'b1;
          end
        end
        COMMIT: begin
          mem_we_q         <= 1'b0;
          used_q[waddr_q]  <= 1'b1;
          dbits_q          <= dbits_q | wdata_q;
          count_q          <= count_d;
          if (count_d == CNT_MAX) begin
            state_q <= FULL;
            done_q  <= 1'b1;
          end else begin
            state_q <= ACCEPT;
          end
        end
        FULL: begin
          mem_we_q <= 1'b0;
        end
        default: begin
          state_q  <= ACCEPT;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign used_addr   = used_q;
  assign used_dbits  = dbits_q;
  assign count       = count_q;
  assign done        = done_q;
  assign err_dup     = edup_q;
  assign err_zero    = ezero_q;
  assign err_overlap = eovl_q;

endmodule

// File: doc/mem_once_writer.md
Name: mem_once_writer

Overview:
- Write-side controller for a 32-entry x 32-bit synchronous memory.
- Accepts (addr, data) write requests on a valid/ready interface and enforces three rules:
  - each address is written at most once;
  - data is nonzero;
  - data bits are disjoint from every previously committed word.
- Legal requests become a single registered write strobe on the memory write port. Illegal requests are dropped and flagged.
- Sits opposite the registered read port of the same memory. It also serves as the stimulus source for memory/VCD demo benches.

Parameters:
- AW, 5, address width; depth = 2**AW.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of all bookkeeping; returns the block to ACCEPT.
- wr_valid  input  1  request valid.
- wr_ready  output  1  block can take a request this cycle.
- wr_addr  input  AW  request address.
- wr_data  input  DW  request data.
- mem_we  output  1  one-cycle write strobe to the memory.
- mem_waddr  output  AW  write address, registered.
- mem_wdata  output  DW  write data, registered.
- used_addr  output  2**AW  bitmap of committed addresses.
- used_dbits  output  DW  OR of all committed data words.
- count  output  AW+1  number of committed writes, 0..2**AW.
- done  output  1  every address has been committed.
- err_dup  output  1  sticky: a request targeted an already-used address.
- err_zero  output  1  sticky: a request carried data == 0.
- err_overlap  output  1  sticky: a request's data overlapped used_dbits.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=ACCEPT.
  - All outputs 0, except wr_ready=1 once resetn is high.
  - Bitmaps, count, errors and the mem_* registers = 0.
- States: ACCEPT, COMMIT, FULL.
- ACCEPT:
  - wr_ready = !clear.
  - A handshake is wr_valid && wr_ready.
  - The legality check is combinational against current state:
    - dup = used_addr[wr_addr];
    - zero = (wr_data == 0);
    - ovl = (wr_data & used_dbits) != 0.
  - Legal (no flag set): latch mem_waddr/mem_wdata, go to COMMIT.
  - Illegal: set each corresponding sticky error (several may set at once); state stays ACCEPT; nothing is written.
- COMMIT (exactly one cycle):
  - mem_we=1 and wr_ready=0.
  - At the end of the cycle:
    - used_addr[mem_waddr] <= 1;
    - used_dbits <= used_dbits | mem_wdata;
    - count <= count+1.
  - Next state is FULL if the new count == 2**AW, else ACCEPT.
- FULL: wr_ready=0, done=1, mem_we=0. Leaves only via clear or reset.
- Throughput and latency:
  - At most one legal request every 2 cycles.
  - mem_we asserts the cycle after the handshake.
  - Bitmaps and count are visible the cycle after mem_we.
  - Back-to-back illegal requests are absorbed at 1 per cycle.
- mem_waddr/mem_wdata hold their last value outside COMMIT.
- clear:
  - Takes priority over everything except reset.
  - In any state: next cycle is ACCEPT with bitmaps, count, errors and done at 0.
  - Asserted during COMMIT: mem_we still pulses that cycle (the memory write happens), but the bookkeeping update is discarded in favour of the clear.
  - While clear=1, wr_ready=0, so no handshake can coincide with it.
- Mid-operation reset (resetn low in any state): immediate return to reset values; mem_we deasserts asynchronously.
- Width rules:
  - count is AW+1 bits and never wraps; FULL blocks further increments.
  - used_dbits is exactly DW bits.
- With DW=32 and AW=5, done is reachable only if each committed word is one-hot. Zero and overlap checks make 32 disjoint nonzero 32-bit words necessarily one-hot.
- No combinational path from wr_valid to wr_ready.

Decomposition:
- Shared package mem_once_pkg:
  - state enum {ACCEPT, COMMIT, FULL};
  - localparams AW=5, DW=32, DEPTH=1<<AW.
- One natural sub-module, mem_once_check: purely combinational dup/zero/overlap evaluation. It is reused by the formal harness that constrains the matching read-side demo.
- FSM, bitmaps and counters stay in the top module.

Test Plan:
- Write (addr=3, data=0x00000001) after reset:
  - handshake at cycle T;
  - mem_we=1, mem_waddr=3, mem_wdata=1 at T+1;
  - used_addr=0x00000008, used_dbits=0x1, count=1 at T+2.
- Duplicate address: (3, 0x1), then (3, 0x2):
  - second request raises err_dup;
  - no second mem_we; count stays 1; used_dbits=0x1.
- Zero and overlap in one request: (5, 0x0) sets err_zero. Then, after committing (6, 0x3), request (7, 0x2):
  - err_overlap=1;
  - count=1 (from the 0x3 write); used_addr bit 7 stays 0.
- Fill with addr=i, data=1<<i for i=0..31, wr_valid held high:
  - 32 mem_we pulses, each 2 cycles apart;
  - count=32, done=1, used_addr=used_dbits=0xFFFFFFFF;
  - wr_ready=0 thereafter.
- clear asserted on the COMMIT cycle of (9, 0x200):
  - mem_we=1 that cycle;
  - next cycle count=0, used_addr=0, errors 0, wr_ready=1.
- resetn pulled low while in FULL: done, mem_we, count and bitmaps go to 0 without a clock edge; wr_ready=1 after release.
